// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: debounces scanner Code/Valid, builds a hex digit
// entry with backspace/enter, and hands it off over a valid/ready handshake.
module keypad_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [3:0]              key_code,
  input  logic                    key_valid,
  input  logic                    entry_ready,
  output logic                    entry_valid,
  output logic [4*MAX_DIGITS-1:0] entry_data,
  output logic [3:0]              entry_len,
  output logic [3:0]              digit_count,
  output logic                    key_ack,
  output logic                    err,
  output logic                    timeout
);

  localparam int          BW   = 4 * MAX_DIGITS;
  localparam logic [7:0]  DB   = 8'(DEBOUNCE_CYCLES);
  localparam logic [31:0] TMO  = 32'(TIMEOUT_CYCLES);
  localparam logic [3:0]  MAXD = 4'(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HELD,
    S_RELEASE_DB
  } state_t;

  state_t          r_state, w_state_nx;
  logic [3:0]      r_cand, w_cand_nx;
  logic [7:0]      r_cnt, w_cnt_nx, w_cnt_inc;
  logic            w_exec;
  logic [3:0]      w_code;

  logic [BW-1:0]   r_buf, w_buf_nx;
  logic [3:0]      r_dcnt, w_dcnt_nx;
  logic [31:0]     r_timer, w_timer_nx;
  logic            r_ev, w_ev_nx;
  logic [BW-1:0]   r_edata, w_edata_nx;
  logic [3:0]      r_elen, w_elen_nx;
  logic            r_ack, w_ack_nx;
  logic            r_err, w_err_nx;
  logic            r_tmo, w_tmo_nx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_dcnt  <= '0;
      r_timer <= '0;
      r_ev    <= 1'b0;
      r_edata <= '0;
      r_elen  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cand  <= w_cand_nx;
      r_cnt   <= w_cnt_nx;
      r_buf   <= w_buf_nx;
      r_dcnt  <= w_dcnt_nx;
      r_timer <= w_timer_nx;
      r_ev    <= w_ev_nx;
      r_edata <= w_edata_nx;
      r_elen  <= w_elen_nx;
      r_ack   <= w_ack_nx;
      r_err   <= w_err_nx;
      r_tmo   <= w_tmo_nx;
    end
  end

  // Debounce FSM: the sample that completes a stable press fires w_exec.
  always_comb begin
    w_state_nx = r_state;
    w_cand_nx  = r_cand;
    w_cnt_nx   = r_cnt;
    w_exec     = 1'b0;
    w_code     = r_cand;
    w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    case (r_state)
      S_IDLE: begin
        if (key_valid) begin
          w_cand_nx = key_code;
          w_code    = key_code;
          w_cnt_nx  = 8'd1;
          if (DB <= 8'd1) begin
            w_exec     = 1'b1;
            w_state_nx = S_HELD;
          end else begin
            w_state_nx = S_PRESS_DB;
          end
        end
      end
      S_PRESS_DB: begin
        if (key_valid && (key_code == r_cand)) begin
          w_cnt_nx = w_cnt_inc;
          if (w_cnt_inc >= DB) begin
            w_exec     = 1'b1;
            w_state_nx = S_HELD;
          end
        end else begin
          w_cnt_nx   = 8'd0;
          w_state_nx = S_IDLE;
        end
      end
      S_HELD: begin
        if (!key_valid) begin
          if (DB <= 8'd1) begin
            w_cnt_nx   = 8'd0;
            w_state_nx = S_IDLE;
          end else begin
            w_cnt_nx   = 8'd1;
            w_state_nx = S_RELEASE_DB;
          end
        end
      end
      S_RELEASE_DB: begin
        if (key_valid) begin
          w_cnt_nx   = 8'd0;
          w_state_nx = S_HELD;
        end else if (w_cnt_inc >= DB) begin
          w_cnt_nx   = 8'd0;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      default: begin
        w_cnt_nx   = 8'd0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Entry buffer, handshake and idle timer; a same-cycle accept frees the
  // output slot before an enter action looks at it.
  always_comb begin
    w_buf_nx   = r_buf;
    w_dcnt_nx  = r_dcnt;
    w_ev_nx    = r_ev & ~entry_ready;
    w_edata_nx = r_edata;
    w_elen_nx  = r_elen;
    w_ack_nx   = 1'b0;
    w_err_nx   = 1'b0;
    w_tmo_nx   = 1'b0;
    w_timer_nx = '0;
    if (w_exec) begin
      w_ack_nx = 1'b1;
      if (w_code < 4'hE) begin
        if (r_dcnt < MAXD) begin
          w_buf_nx  = BW'({r_buf, w_code});
          w_dcnt_nx = r_dcnt + 4'd1;
        end else begin
          w_err_nx = 1'b1;
        end
      end else if (w_code == 4'hE) begin
        if (r_dcnt != 4'd0) begin
          w_buf_nx  = r_buf >> 4;
          w_dcnt_nx = r_dcnt - 4'd1;
        end
      end else if (r_dcnt != 4'd0) begin
        if (r_ev && !entry_ready) begin
          w_err_nx = 1'b1;
        end else begin
          w_edata_nx = r_buf;
          w_elen_nx  = r_dcnt;
          w_ev_nx    = 1'b1;
          w_buf_nx   = '0;
          w_dcnt_nx  = 4'd0;
        end
      end
    end else if ((r_state == S_IDLE) && !key_valid && (r_dcnt != 4'd0) && (TMO != 32'd0)) begin
      if ((r_timer + 32'd1) >= TMO) begin
        w_buf_nx  = '0;
        w_dcnt_nx = 4'd0;
        w_tmo_nx  = 1'b1;
      end else begin
        w_timer_nx = r_timer + 32'd1;
      end
    end
  end

  assign entry_valid = r_ev;
  assign entry_data  = r_edata;
  assign entry_len   = r_elen;
  assign digit_count = r_dcnt;
  assign key_ack     = r_ack;
  assign err         = r_err;
  assign timeout     = r_tmo;

endmodule
